// File: rtl/adc_logger_pkg.sv
// Shared types and constants for the ADC frame packer.
// Contents: sample/byte widths, the default frame sync byte and the packer FSM state type.
package adc_logger_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Each state names the byte currently presented on tx_data.
  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSeq,
    StDhi,
    StDlo,
    StChk
  } pack_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO.
// Ports:
//   clk, res       clock, synchronous active-high reset (flushes the FIFO)
//   push, din      write din when push=1 and not full
//   pop            drop the head when pop=1 and not empty
//   dout           current head word
//   dout_next      word behind the head, valid when level >= 2
//   level          words currently held
//   full, empty    occupancy flags derived from level
module sample_fifo
  import adc_logger_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    push,
  input  logic                    pop,
  input  logic [SAMPLE_W-1:0]     din,
  output logic [SAMPLE_W-1:0]     dout,
  output logic [SAMPLE_W-1:0]     dout_next,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         level_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign level     = level_q;
  assign dout      = mem_q[rd_ptr_q];
  // Lets the consumer register the next head's byte on the same edge that pops.
  assign dout_next = mem_q[rd_ptr_q + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs ADC samples into framed byte stream: SYNC, SEQ, {hi, lo} x N, CHK.
// CHK is the XOR of the SEQ byte and every data byte.
// Ports:
//   clk, res              clock, synchronous active-high reset
//   drdy, adc_data        sample strobe (rising edge captures adc_data) and sample word
//   tx_data, tx_valid     registered output byte and its valid flag
//   tx_ready              sink ready; transfer on an edge with tx_valid && tx_ready
//   ovr_clr, overrun      clear and sticky flag for samples dropped on a full FIFO
//   fifo_level            samples held in the FIFO
//   frame_seq             sequence number of the frame being or next to be sent
module adc_frame_packer
  import adc_logger_pkg::*;
#(
  parameter int unsigned       SAMPLES_PER_FRAME = 4,
  parameter int unsigned       FIFO_DEPTH        = 16,
  parameter logic [BYTE_W-1:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          drdy,
  input  logic [SAMPLE_W-1:0]           adc_data,
  output logic [BYTE_W-1:0]             tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic                          ovr_clr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [BYTE_W-1:0]             frame_seq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;

  pack_state_e         state_q;
  logic                drdy_q;
  logic                rise;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;
  logic                xfer;
  logic                last_sample;
  logic [CW-1:0]       cnt_q;
  logic [BYTE_W-1:0]   chk_q;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W-1:0] head_next;
  logic [SAMPLE_W-1:0] word_sel;

  assign rise      = drdy & ~drdy_q;
  // Fullness comes from the level at the start of the cycle, so a same-cycle pop
  // does not rescue a sample arriving on a full FIFO.
  assign fifo_push = rise & ~fifo_full;
  assign drop      = rise & fifo_full;

  assign xfer        = tx_valid & tx_ready;
  assign fifo_pop    = xfer & (state_q == StDlo) & ~fifo_empty;
  assign last_sample = (cnt_q == CW'(SAMPLES_PER_FRAME - 1));

  // On a DLO transfer the head is popped, so the next high byte comes from the word behind it.
  assign word_sel = (state_q == StDlo) ? head_next : head;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (adc_data),
    .dout      (head),
    .dout_next (head_next),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      drdy_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      drdy_q <= drdy;
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= StIdle;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      chk_q     <= '0;
      cnt_q     <= '0;
      frame_seq <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_level >= LW'(SAMPLES_PER_FRAME)) begin
            state_q  <= StSync;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
            chk_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StSync: begin
          if (xfer) begin
            state_q <= StSeq;
            tx_data <= frame_seq;
          end
        end
        StSeq: begin
          if (xfer) begin
            state_q <= StDhi;
            tx_data <= word_sel[15:8];
            chk_q   <= chk_q ^ tx_data;
          end
        end
        StDhi: begin
          if (xfer) begin
            state_q <= StDlo;
            tx_data <= word_sel[7:0];
            chk_q   <= chk_q ^ tx_data;
          end
        end
        StDlo: begin
          if (xfer) begin
            chk_q <= chk_q ^ tx_data;
            if (last_sample) begin
              state_q <= StChk;
              tx_data <= chk_q ^ tx_data;
            end else begin
              state_q <= StDhi;
              cnt_q   <= cnt_q + CW'(1);
              tx_data <= word_sel[15:8];
            end
          end
        end
        StChk: begin
          if (xfer) begin
            state_q   <= StIdle;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            frame_seq <= frame_seq + 8'd1;
          end
        end
        default: begin
          state_q  <= StIdle;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer (N=4, FIFO depth 16).
module tb_adc_frame_packer;

  logic        clk;
  logic        res;
  logic        drdy;
  logic [15:0] adc_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ovr_clr;
  logic        overrun;
  logic [4:0]  fifo_level;
  logic [7:0]  frame_seq;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rx_q [$];
  logic [15:0] smp [4];

  adc_frame_packer #(
    .SAMPLES_PER_FRAME (4),
    .FIFO_DEPTH        (16),
    .SYNC_BYTE         (8'hA5)
  ) dut (
    .clk        (clk),
    .res        (res),
    .drdy       (drdy),
    .adc_data   (adc_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun),
    .fifo_level (fifo_level),
    .frame_seq  (frame_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change 1 time unit after posedge, so what is seen here holds at the next edge.
  always @(negedge clk) begin
    if (!res && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] d);
    adc_data = d;
    drdy     = 1'b1;
    tick();
    drdy     = 1'b0;
    adc_data = 16'h0;
    tick();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int left;
    left = budget;
    while (rx_q.size() < n && left > 0) begin
      tick();
      left--;
    end
    check_eq("bytes_received", 32'(rx_q.size() >= n), 32'd1);
  endtask

  // Expected frame built from smp[] and the sequence number; CHK excludes SYNC.
  task automatic expect_frame(input logic [7:0] seq);
    logic [7:0] exp_b [11];
    logic [7:0] chk;
    exp_b[0] = 8'hA5;
    exp_b[1] = seq;
    chk = seq;
    for (int j = 0; j < 4; j++) begin
      exp_b[2 + 2 * j] = smp[j][15:8];
      exp_b[3 + 2 * j] = smp[j][7:0];
      chk = chk ^ smp[j][15:8] ^ smp[j][7:0];
    end
    exp_b[10] = chk;
    wait_bytes(11, 300);
    if (rx_q.size() >= 11) begin
      for (int b = 0; b < 11; b++) begin
        check_eq($sformatf("frame%0d_byte%0d", seq, b), 32'(rx_q.pop_front()), 32'(exp_b[b]));
      end
    end
  endtask

  initial begin
    int left;
    res      = 1'b1;
    drdy     = 1'b0;
    adc_data = 16'h0;
    tx_ready = 1'b1;
    ovr_clr  = 1'b0;
    tick();
    tick();
    res = 1'b0;

    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_seq", 32'(frame_seq), 32'd0);

    // Nominal frame
    for (int j = 0; j < 4; j++) begin
      smp[j] = 16'(j + 1);
      send_sample(smp[j]);
    end
    expect_frame(8'h00);
    tick();
    tick();
    check_eq("nom_seq", 32'(frame_seq), 32'd1);
    check_eq("nom_level", 32'(fifo_level), 32'd0);
    check_eq("nom_idle_valid", 32'(tx_valid), 32'd0);

    // Backpressure on the 0x02 byte
    for (int j = 0; j < 4; j++) send_sample(smp[j]);
    left = 100;
    while (!(tx_valid && tx_data == 8'h02) && left > 0) begin
      tick();
      left--;
    end
    check_eq("bp_reached_02", 32'(tx_valid && tx_data == 8'h02), 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_valid", 32'(tx_valid), 32'd1);
      check_eq("bp_hold_data", 32'(tx_data), 32'h02);
    end
    tx_ready = 1'b1;
    expect_frame(8'h01);
    tick();
    tick();
    check_eq("bp_seq", 32'(frame_seq), 32'd2);

    // Overrun: 17 samples into a 16-deep FIFO with the sink stalled
    tx_ready = 1'b0;
    for (int k = 0; k < 17; k++) send_sample(16'(k));
    check_eq("ovr_level", 32'(fifo_level), 32'd16);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    tx_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 4; j++) smp[j] = 16'(f * 4 + j);
      expect_frame(8'(2 + f));
    end
    for (int i = 0; i < 10; i++) tick();
    check_eq("ovr_no_extra_bytes", 32'(rx_q.size()), 32'd0);
    check_eq("ovr_level_drained", 32'(fifo_level), 32'd0);
    check_eq("ovr_still_set", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("ovr_cleared", 32'(overrun), 32'd0);

    // drdy held high writes one sample
    adc_data = 16'hBEEF;
    drdy     = 1'b1;
    tick();
    tick();
    tick();
    drdy = 1'b0;
    tick();
    check_eq("level_drdy", 32'(fifo_level), 32'd1);

    // Reset during the first DHI byte of the next frame
    send_sample(16'h1111);
    send_sample(16'h2222);
    send_sample(16'h3333);
    left = 100;
    while (!(tx_valid && tx_data == 8'hBE) && left > 0) begin
      tick();
      left--;
    end
    check_eq("rstmid_reached_dhi", 32'(tx_valid && tx_data == 8'hBE), 32'd1);
    tx_ready = 1'b0;
    res      = 1'b1;
    tick();
    res = 1'b0;
    check_eq("rstmid_valid", 32'(tx_valid), 32'd0);
    check_eq("rstmid_level", 32'(fifo_level), 32'd0);
    check_eq("rstmid_seq", 32'(frame_seq), 32'd0);
    rx_q.delete();
    tx_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      smp[j] = 16'hC000 + 16'(j * 16'h0123);
      send_sample(smp[j]);
    end
    expect_frame(8'h00);

    // Sequence wrap: frames 2..257 since the reset, SEQ runs 01..FF then 00
    for (int k = 1; k <= 256; k++) begin
      for (int j = 0; j < 4; j++) begin
        smp[j] = 16'(k * 37 + j * 4099);
        send_sample(smp[j]);
      end
      expect_frame(8'(k));
    end
    tick();
    tick();
    check_eq("wrap_seq_after", 32'(frame_seq), 32'd1);
    check_eq("wrap_level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
